// File: rtl/flush_sequencer.sv
// Recovery sequencer: turns a committed exception or a fence request into an
// ordered abort / synch / clear / redirect sequence for the front end and memory system.
module flush_sequencer #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned EXC_W      = 4,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             except_raised_i,
  input  logic [EXC_W-1:0] except_code_i,
  input  logic [XLEN-1:0]  except_pc_i,
  input  logic [XLEN-1:0]  trap_vector_i,
  input  logic             fence_req_i,
  input  logic [XLEN-1:0]  fence_pc_i,
  output logic             fence_ack_o,
  input  logic             l2c_update_done_i,
  output logic             synch_l1dc_l2c_o,
  output logic             flush_o,
  output logic             abort_o,
  output logic             clr_l1tlb_mshr_o,
  output logic             clr_l2tlb_mshr_o,
  output logic             clear_dmshr_dregs_o,
  output logic             stall_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [XLEN-1:0]  epc_o,
  output logic [EXC_W-1:0] ecause_o
);

  localparam int unsigned CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ABORT    = 3'd1,
    SYNCH    = 3'd2,
    CLEAR    = 3'd3,
    REDIRECT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fence_q, fence_d;
  logic [XLEN-1:0]  epc_d, rpc_d;
  logic [EXC_W-1:0] ecause_d;
  logic             clear_d;

  // Next-state, captured-context and counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fence_d  = fence_q;
    epc_d    = epc_o;
    ecause_d = ecause_o;
    rpc_d    = redirect_pc_o;
    case (state_q)
      IDLE: begin
        if (except_raised_i) begin
          epc_d    = except_pc_i;
          ecause_d = except_code_i;
          rpc_d    = trap_vector_i;
          fence_d  = 1'b0;
          state_d  = ABORT;
        end else if (fence_req_i) begin
          rpc_d   = fence_pc_i + XLEN'(4);
          fence_d = 1'b1;
          state_d = SYNCH;
        end
      end
      ABORT: begin
        cnt_d   = CNT_W'(CLR_CYCLES - 1);
        state_d = CLEAR;
      end
      SYNCH: begin
        if (l2c_update_done_i) begin
          cnt_d   = CNT_W'(CLR_CYCLES - 1);
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = REDIRECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state so they appear with the state
  assign clear_d = (state_d == CLEAR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      fence_q             <= 1'b0;
      fence_ack_o         <= 1'b0;
      synch_l1dc_l2c_o    <= 1'b0;
      flush_o             <= 1'b0;
      abort_o             <= 1'b0;
      clr_l1tlb_mshr_o    <= 1'b0;
      clr_l2tlb_mshr_o    <= 1'b0;
      clear_dmshr_dregs_o <= 1'b0;
      stall_o             <= 1'b0;
      redirect_valid_o    <= 1'b0;
      redirect_pc_o       <= '0;
      epc_o               <= '0;
      ecause_o            <= '0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      fence_q             <= fence_d;
      fence_ack_o         <= (state_d == REDIRECT) && fence_d;
      synch_l1dc_l2c_o    <= (state_d == SYNCH);
      flush_o             <= (state_d == ABORT) || clear_d;
      abort_o             <= (state_d == ABORT);
      clr_l1tlb_mshr_o    <= clear_d;
      clr_l2tlb_mshr_o    <= clear_d;
      clear_dmshr_dregs_o <= clear_d;
      stall_o             <= (state_d != IDLE);
      redirect_valid_o    <= (state_d == REDIRECT);
      redirect_pc_o       <= rpc_d;
      epc_o               <= epc_d;
      ecause_o            <= ecause_d;
    end
  end

endmodule
